// File: rtl/psdsqrt_pkg.sv
// Shared definitions for the square-root sequencer: controller states and
// iteration-count helpers tied to the operand width.
package psdsqrt_pkg;

    // Default operand width of the shared sqrt core.
    localparam int DEF_NBITSIN = 32;

    // Controller state encoding.
    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_RUN  = 2'd1,
        S_STOP = 2'd2,
        S_DONE = 2'd3
    } state_t;

    // The core resolves one result bit per iteration.
    function automatic int sqrt_iters(input int nbits);
        return nbits / 2;
    endfunction

    localparam int SQRT_ITERS = DEF_NBITSIN / 2;

endpackage

// File: rtl/psdsqrt_ctrl_rrarb.sv
// Round-robin arbiter for the sqrt sequencer. The grant is purely
// combinational from the request vector and the priority pointer; the pointer
// moves one past the winner whenever the controller consumes a grant.
import psdsqrt_pkg::*;

module psdsqrt_rrarb #(
    parameter int NREQ = 2,
    parameter int IDW  = $clog2(NREQ)
) (
    input  logic            clock,
    input  logic            reset,
    input  logic [NREQ-1:0] req_valid,
    input  logic            advance,
    output logic            grant_any,
    output logic [IDW-1:0]  grant_idx
);

    logic [IDW-1:0] ptr;
    logic [IDW-1:0] probe;
    int             pos;

    // Search from ptr upward with wrap; scanning from the far end down lets
    // the nearest valid index win without an early exit.
    always_comb begin
        grant_any = 1'b0;
        grant_idx = '0;
        pos       = 0;
        probe     = '0;
        for (int k = NREQ - 1; k >= 0; k--) begin
            pos = int'(ptr) + k;
            if (pos >= NREQ) begin
                pos = pos - NREQ;
            end
            probe = IDW'(pos);
            if (req_valid[probe]) begin
                grant_any = 1'b1;
                grant_idx = probe;
            end
        end
    end

    // Priority pointer: restarts at 0, moves past the winner on a taken grant.
    always_ff @(posedge clock) begin
        if (reset) begin
            ptr <= '0;
        end else if (advance && grant_any) begin
            if (grant_idx == IDW'(NREQ - 1)) begin
                ptr <= '0;
            end else begin
                ptr <= grant_idx + 1'b1;
            end
        end
    end

endmodule

// File: rtl/psdsqrt_ctrl.sv
// Sequencer for the shared iterative square-root core: arbitrates between
// requesters, issues start/stop with fixed iteration timing and presents the
// tagged result on a valid/ready port.
import psdsqrt_pkg::*;

module psdsqrt_ctrl #(
    parameter int NBITSIN = DEF_NBITSIN,
    parameter int NREQ    = 2,
    parameter int IDW     = $clog2(NREQ)
) (
    input  logic                    clock,
    input  logic                    reset,
    input  logic [NREQ-1:0]         req_valid,
    input  logic [NREQ*NBITSIN-1:0] req_xin,
    output logic [NREQ-1:0]         req_ready,
    output logic                    core_start,
    output logic [NBITSIN-1:0]      core_xin,
    output logic                    core_stop,
    input  logic [NBITSIN/2-1:0]    core_sqrt,
    output logic                    res_valid,
    input  logic                    res_ready,
    output logic [NBITSIN/2-1:0]    res_sqrt,
    output logic [IDW-1:0]          res_id,
    output logic                    busy
);

    localparam int ITERS = sqrt_iters(NBITSIN);
    localparam int CNTW  = $clog2(ITERS);
    localparam int HW    = NBITSIN / 2;

    state_t          state;
    logic [CNTW-1:0] cnt;
    logic [IDW-1:0]  id_q;
    logic [HW-1:0]   res_q;
    logic            done_first;

    logic            grant_any;
    logic [IDW-1:0]  grant_idx;
    logic            accept;

    // A grant is only taken from IDLE and never while reset is asserted.
    assign accept = (state == S_IDLE) && grant_any && !reset;

    psdsqrt_rrarb #(
        .NREQ (NREQ),
        .IDW  (IDW)
    ) u_rrarb (
        .clock     (clock),
        .reset     (reset),
        .req_valid (req_valid),
        .advance   (accept),
        .grant_any (grant_any),
        .grant_idx (grant_idx)
    );

    // One-hot accept pulse to the granted requester.
    always_comb begin
        req_ready = '0;
        if (accept) begin
            req_ready[grant_idx] = 1'b1;
        end
    end

    assign core_start = accept;
    assign core_xin   = accept ? req_xin[int'(grant_idx)*NBITSIN +: NBITSIN] : '0;
    assign core_stop  = (state == S_STOP) && !reset;
    assign busy       = (state != S_IDLE);
    assign res_valid  = (state == S_DONE);
    assign res_id     = res_valid ? id_q : '0;

    // The core result is valid from the first DONE cycle; after that the
    // captured copy keeps the output frozen for the rest of a stall.
    assign res_sqrt   = !res_valid ? '0 : (done_first ? core_sqrt : res_q);

    // Main sequencer: accept, count iterations, pulse stop, hold result.
    always_ff @(posedge clock) begin
        if (reset) begin
            state      <= S_IDLE;
            cnt        <= '0;
            id_q       <= '0;
            res_q      <= '0;
            done_first <= 1'b0;
        end else begin
            case (state)
                S_IDLE: begin
                    if (grant_any) begin
                        id_q  <= grant_idx;
                        cnt   <= CNTW'(1);
                        state <= S_RUN;
                    end
                end
                S_RUN: begin
                    if (cnt == CNTW'(ITERS - 1)) begin
                        cnt   <= '0;
                        state <= S_STOP;
                    end else begin
                        cnt <= cnt + 1'b1;
                    end
                end
                S_STOP: begin
                    done_first <= 1'b1;
                    state      <= S_DONE;
                end
                S_DONE: begin
                    done_first <= 1'b0;
                    if (done_first) begin
                        res_q <= core_sqrt;
                    end
                    if (res_ready) begin
                        state <= S_IDLE;
                    end
                end
                default: state <= S_IDLE;
            endcase
        end
    end

    // Start and stop must never coincide on the core pins.
    a_start_stop_excl: assert property (@(posedge clock) disable iff (reset)
        !(core_start && core_stop));

    // A stalled result must not change under the consumer.
    a_res_stable: assert property (@(posedge clock) disable iff (reset)
        (res_valid && !res_ready) |=> ($stable(res_sqrt) && $stable(res_id)));

endmodule

// File: tb/tb_psdsqrt_ctrl.sv
// Directed bench for psdsqrt_ctrl with a behavioural model of the sqrt core.
module tb_psdsqrt_ctrl;

    logic        clock;
    logic        reset;
    logic [1:0]  req_valid;
    logic [63:0] req_xin;
    logic [1:0]  req_ready;
    logic        core_start;
    logic [31:0] core_xin;
    logic        core_stop;
    logic [15:0] core_sqrt;
    logic        res_valid;
    logic        res_ready;
    logic [15:0] res_sqrt;
    logic [0:0]  res_id;
    logic        busy;

    int n_tests = 0;
    int n_fail  = 0;

    psdsqrt_ctrl #(.NBITSIN(32), .NREQ(2), .IDW(1)) dut (
        .clock      (clock),
        .reset      (reset),
        .req_valid  (req_valid),
        .req_xin    (req_xin),
        .req_ready  (req_ready),
        .core_start (core_start),
        .core_xin   (core_xin),
        .core_stop  (core_stop),
        .core_sqrt  (core_sqrt),
        .res_valid  (res_valid),
        .res_ready  (res_ready),
        .res_sqrt   (res_sqrt),
        .res_id     (res_id),
        .busy       (busy)
    );

    initial clock = 1'b0;
    always #5 clock = ~clock;

    function automatic logic [15:0] isqrt(input logic [31:0] x);
        logic [15:0] r;
        logic [15:0] t;
        r = '0;
        for (int b = 15; b >= 0; b--) begin
            t = r | (16'd1 << b);
            if (longint'(t) * longint'(t) <= longint'(x)) r = t;
        end
        return r;
    endfunction

    // Core model: latch operand on start, load result at the end of the stop cycle.
    logic [31:0] core_x;
    initial begin
        core_x    = '0;
        core_sqrt = '0;
    end
    always @(posedge clock) begin
        if (core_start) core_x <= core_xin;
        if (core_stop)  core_sqrt <= isqrt(core_x);
    end

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_tests++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, got, exp);
        end
    endtask

    // One operation from the current negedge (state IDLE) back to IDLE.
    task automatic op(input string tag, input logic [1:0] vmask, input int idx,
                      input logic [31:0] x, input logic [15:0] exp, input int stall);
        int stop_at;
        int stops;
        int starts;
        logic [15:0] held_sqrt;
        stop_at = 0;
        stops   = 0;
        starts  = 0;
        req_xin[idx*32 +: 32] = x;
        req_valid = vmask;
        res_ready = (stall == 0);
        #1;
        chk({tag, " ready"}, 32'(req_ready), 32'(1 << idx));
        chk({tag, " start"}, 32'(core_start), 32'd1);
        chk({tag, " xin"}, core_xin, x);
        @(negedge clock);
        req_valid = '0;
        for (int c = 1; c <= 16; c++) begin
            if (core_stop && stop_at == 0) stop_at = c;
            stops  += int'(core_stop);
            starts += int'(core_start);
            if (c == 5) chk({tag, " xin_idle"}, core_xin, 32'd0);
            @(negedge clock);
        end
        chk({tag, " stop_cycle"}, 32'(stop_at), 32'd16);
        chk({tag, " stop_count"}, 32'(stops), 32'd1);
        chk({tag, " start_count"}, 32'(starts), 32'd0);
        chk({tag, " res_valid"}, 32'(res_valid), 32'd1);
        chk({tag, " res_sqrt"}, 32'(res_sqrt), 32'(exp));
        chk({tag, " res_id"}, 32'(res_id), 32'(idx));
        held_sqrt = exp;
        if (stall > 0) begin
            req_valid = 2'b11;
            for (int s = 0; s < stall; s++) begin
                @(negedge clock);
                #1;
                chk({tag, " stall_valid"}, 32'(res_valid), 32'd1);
                chk({tag, " stall_sqrt"}, 32'(res_sqrt), 32'(held_sqrt));
                chk({tag, " stall_id"}, 32'(res_id), 32'(idx));
                chk({tag, " stall_ready"}, 32'(req_ready), 32'd0);
            end
            req_valid = '0;
            res_ready = 1'b1;
        end
        @(negedge clock);
        chk({tag, " idle_busy"}, 32'(busy), 32'd0);
        chk({tag, " idle_valid"}, 32'(res_valid), 32'd0);
    endtask

    int acc_cyc [4];
    logic [1:0] acc_vec [4];
    logic [15:0] r_val [4];
    logic [0:0] r_id [4];
    int na;
    int nr;
    int stop_seen;

    initial begin
        reset     = 1'b1;
        req_valid = '0;
        req_xin   = '0;
        res_ready = 1'b1;
        repeat (3) @(negedge clock);
        chk("rst busy", 32'(busy), 32'd0);
        chk("rst res_valid", 32'(res_valid), 32'd0);
        chk("rst core_stop", 32'(core_stop), 32'd0);
        chk("rst res_sqrt", 32'(res_sqrt), 32'd0);
        reset = 1'b0;
        #1;
        chk("rst req_ready", 32'(req_ready), 32'd0);
        chk("rst core_xin", core_xin, 32'd0);
        @(negedge clock);

        op("sqrt16", 2'b01, 0, 32'h0000_0010, 16'd4, 0);
        op("zero",   2'b01, 0, 32'h0000_0000, 16'd0, 0);
        op("max",    2'b10, 1, 32'hFFFF_FFFF, 16'hFFFF, 0);
        op("two",    2'b01, 0, 32'h0000_0002, 16'd1, 0);

        // Both requesters continuously valid from reset.
        reset     = 1'b1;
        req_xin   = {32'd1000000, 32'd144};
        req_valid = 2'b11;
        res_ready = 1'b1;
        @(negedge clock);
        @(negedge clock);
        #1;
        chk("rr ready_in_reset", 32'(req_ready), 32'd0);
        reset = 1'b0;
        na = 0;
        nr = 0;
        for (int cyc = 0; cyc < 72; cyc++) begin
            #1;
            if (req_ready != 2'b00 && na < 4) begin
                acc_cyc[na] = cyc;
                acc_vec[na] = req_ready;
                na++;
            end
            if (res_valid && nr < 4) begin
                r_val[nr] = res_sqrt;
                r_id[nr]  = res_id;
                nr++;
            end
            @(negedge clock);
        end
        req_valid = '0;
        chk("rr accepts", 32'(na), 32'd4);
        chk("rr results", 32'(nr), 32'd4);
        for (int k = 0; k < 4; k++) begin
            if (k < na) begin
                chk($sformatf("rr grant%0d", k), 32'(acc_vec[k]), (k % 2 == 0) ? 32'd1 : 32'd2);
                chk($sformatf("rr acc_cycle%0d", k), 32'(acc_cyc[k]), 32'(18 * k));
            end
            if (k < nr) begin
                chk($sformatf("rr val%0d", k), 32'(r_val[k]), (k % 2 == 0) ? 32'd12 : 32'd1000);
                chk($sformatf("rr id%0d", k), 32'(r_id[k]), 32'(k % 2));
            end
        end
        @(negedge clock);

        op("stall", 2'b10, 1, 32'h0000_0400, 16'd32, 4);

        // Reset in the middle of an operation granted to requester 0.
        req_xin[31:0] = 32'h0000_0010;
        req_valid     = 2'b01;
        #1;
        chk("mid ready", 32'(req_ready), 32'd1);
        @(negedge clock);
        req_valid = '0;
        repeat (7) @(negedge clock);
        chk("mid busy", 32'(busy), 32'd1);
        reset = 1'b1;
        @(negedge clock);
        reset = 1'b0;
        #1;
        chk("mid busy_after", 32'(busy), 32'd0);
        chk("mid valid_after", 32'(res_valid), 32'd0);
        chk("mid stop_after", 32'(core_stop), 32'd0);
        chk("mid start_after", 32'(core_start), 32'd0);
        chk("mid xin_after", core_xin, 32'd0);
        chk("mid sqrt_after", 32'(res_sqrt), 32'd0);
        chk("mid id_after", 32'(res_id), 32'd0);
        stop_seen = 0;
        for (int c = 0; c < 20; c++) begin
            @(negedge clock);
            stop_seen += int'(core_stop);
        end
        chk("mid no_stop", 32'(stop_seen), 32'd0);
        req_xin[63:32] = 32'h0000_0019;
        op("after_rst", 2'b11, 0, 32'h0000_0051, 16'd9, 0);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

    // Global watchdog so the run always ends.
    initial begin
        #200000;
        $display("FAIL watchdog: got timeout, expected completion");
        $fatal(1);
    end

endmodule
